b_io_l3_in_serialize_b_m_axi_fifo_ctrl: RTL and testbench
=========================================================

# b_io_l3_in_serialize_b_m_axi_fifo_ctrl

First-word-fall-through FIFO controller that sequences the m_axi buffer RAM used by the B_IO_L3_in_serialize_B read path. The RAM is a simple dual-port array with DEPTH-1 entries, a registered read address and a registered, `re`-gated output. This block owns the write/read pointers, occupancy and the two-stage read pipeline. It presents a valid/ready FIFO interface to the burst engine (write side) and the serializer (read side), with total capacity DEPTH words.

## Interface
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 6, RAM address width; 2**ADDR_WIDTH ≥ DEPTH-1.
- DEPTH, 63, total FIFO capacity: DEPTH-1 RAM entries plus 1 output word.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- if_write  in  1  push request; accepted only when if_full_n=1.
- if_din  in  DATA_WIDTH  push data.
- if_full_n  out  1  1 = push will be accepted.
- if_read  in  1  pop request; effective only when if_empty_n=1.
- if_dout  out  DATA_WIDTH  head word, equals mem_dout.
- if_empty_n  out  1  1 = if_dout holds valid head word.
- if_num_data_valid  out  ADDR_WIDTH+1  words held, RAM plus output word.
- mem_clk_en  out  1  constant 1.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  ADDR_WIDTH  RAM write address.
- mem_din  out  DATA_WIDTH  RAM write data, equals if_din.
- mem_raddr  out  ADDR_WIDTH  RAM read address, captured by RAM every cycle.
- mem_re  out  1  RAM output-register load enable.
- mem_dout  in  DATA_WIDTH  RAM output register.

## Operation
- State: wptr and rptr (0..DEPTH-2, wrap DEPTH-2→0). used is the count of RAM words not yet loaded into the output, range 0..DEPTH-1. s1_valid/s1_addr marks an address in the RAM raddr register. s2_valid drives if_empty_n.
- Push: push = if_write & if_full_n. mem_we=push, mem_waddr=wptr. wptr advances with wrap.
- Load (S1→S2): load = s1_valid & (~s2_valid | if_read). mem_re = ~s2_valid | if_read. s2_valid ← load | (s2_valid & ~if_read).
- Issue (→S1): issue = (used - s1_valid) > 0 & (~s1_valid | load). On issue: mem_raddr=rptr, s1_addr←rptr, s1_valid←1, rptr advances. Without issue: mem_raddr = s1_valid ? s1_addr : rptr, so a stalled S1 keeps the RAM raddr register stable. s1_valid←0 when load & ~issue.
- used ← used + push - load. Push and load in the same cycle leave used unchanged.
- if_full_n = (used != DEPTH-1), combinational from the register.
- if_num_data_valid = used + s2_valid.
- A pop when if_empty_n=0 is ignored. A push when if_full_n=0 is ignored and RAM is not written.
- A RAM entry is freed only on load. An issued-but-unloaded entry is never overwritten.

## Timing
- Reset values: wptr=rptr=used=0, s1_valid=s2_valid=0. if_full_n=1, if_empty_n=0, if_num_data_valid=0, mem_we=0, mem_raddr=0, mem_re=1. The RAM output-register reset is tied by the parent to ~reset. Its value is don't-care while s2_valid=0.
- Write-to-read latency for an empty FIFO: push in cycle 0, issue in cycle 1, load at the end of cycle 2, if_empty_n=1 in cycle 3.
- Throughput is 1 push and 1 pop per cycle sustained, with no bubbles once S1 and S2 are full.
- A pop in cycle n with S1 valid gives the next word on if_dout in cycle n+1.
- Reset asserted mid-operation immediately clears all state and empties the FIFO. Data in flight is discarded.
- Full: used=DEPTH-1 with S2 valid gives if_num_data_valid=DEPTH. A pop that cycle raises if_full_n the next cycle.

## Test plan
- Reset, then single push 0xA5A5_0001 in cycle 0: if_empty_n=1 first in cycle 3, if_dout=0xA5A5_0001. A pop in cycle 3 gives if_empty_n=0 in cycle 4 and if_num_data_valid=0.
- Push 63 words 0..62 back-to-back with no pops: if_full_n drops after the 62nd RAM word is retained, and if_num_data_valid=63. A 64th push is ignored. Draining returns 0..62 in order, with no duplicates.
- Continuous push and pop every cycle for 500 words, incrementing data: output is in order, no gaps after fill, and if_num_data_valid is stable at ≤3.
- Random if_read stalls (50%) with continuous pushes across ≥3 pointer wraps: the sequence is intact and if_dout is stable while if_read=0 and if_empty_n=1.
- Simultaneous push and pop while full (used=62, S2 valid): data is preserved, if_full_n stays as defined, and no overwrite of the S1 entry occurs.
- reset pulsed low mid-stream with 20 words held: all outputs go to reset values asynchronously. A subsequent push of 0x1234 is the next word read.

Source files
------------

// File: rtl/b_io_l3_in_serialize_b_m_axi_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// b_io_l3_in_serialize_b_m_axi_fifo_ctrl
//
// First-word-fall-through FIFO controller for the m_axi buffer RAM of the
// B_IO_L3_in_serialize_B read path. The external RAM is a simple dual-port
// array of DEPTH-1 words with a registered read address (captured every
// cycle) and a registered output that loads only when mem_re=1. This block
// owns the pointers, the occupancy count and the two-stage read pipeline:
//   S1 : an address sitting in the RAM read-address register
//   S2 : a word sitting in the RAM output register (the FIFO head)
// Total capacity is DEPTH words: DEPTH-1 in RAM plus the output word.
//
// Ports
//   clk               sole clock, rising edge
//   reset             asynchronous, active-low
//   if_write/if_din   push request and data (taken when if_full_n=1)
//   if_full_n         1 = a push will be accepted
//   if_read           pop request (effective when if_empty_n=1)
//   if_dout           head word (straight from the RAM output register)
//   if_empty_n        1 = if_dout holds a valid head word
//   if_num_data_valid words held, RAM plus output word
//   mem_*             RAM control: clock enable, write port, read address,
//                     output-register load enable, output data
// ---------------------------------------------------------------------------
module b_io_l3_in_serialize_b_m_axi_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  // write side (burst engine)
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  // read side (serializer)
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  // RAM side
  output logic                  mem_clk_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int UW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 2);
  localparam logic [UW-1:0]         USED_FULL = UW'(DEPTH - 1);

  // Pointers walk 0..DEPTH-2 and wrap; DEPTH-1 need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [UW-1:0]         used_q, used_d;     // RAM words not yet in the output register
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic                  s2_valid_q, s2_valid_d;

  logic          push;
  logic          load;
  logic          issue;
  logic [UW-1:0] avail;                      // RAM words not yet issued into S1

  assign push  = if_write & if_full_n;
  assign mem_re = ~s2_valid_q | if_read;
  assign load  = s1_valid_q & mem_re;
  // used always counts the S1 entry, so this never underflows.
  assign avail = used_q - UW'(s1_valid_q);
  assign issue = (avail != '0) & (~s1_valid_q | load);

  // NOTE: every combinational output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;

    if (push) wptr_d = next_ptr(wptr_q);

    if (issue) begin
      rptr_d     = next_ptr(rptr_q);
      s1_addr_d  = rptr_q;
      s1_valid_d = 1'b1;
    end else if (load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = load | (s2_valid_q & ~if_read);
    used_d     = used_q + UW'(push) - UW'(load);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      used_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      used_q     <= used_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // The RAM recaptures raddr every cycle; a stalled S1 must re-present its
  // own address so the pending read is not lost.
  assign mem_raddr = issue      ? rptr_q    :
                     s1_valid_q ? s1_addr_q : rptr_q;

  assign mem_clk_en        = 1'b1;
  assign mem_we            = push;
  assign mem_waddr         = wptr_q;
  assign mem_din           = if_din;
  assign if_dout           = mem_dout;
  assign if_empty_n        = s2_valid_q;
  assign if_full_n         = (used_q != USED_FULL);
  assign if_num_data_valid = used_q + UW'(s2_valid_q);

endmodule

// File: tb/tb_b_io_l3_in_serialize_b_m_axi_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for b_io_l3_in_serialize_b_m_axi_fifo_ctrl.
// A behavioural RAM (registered raddr, re-gated output register reset by
// the FIFO reset) sits beside the controller. The reference model is a
// queue of (word, push cycle): the head word is visible once it was pushed
// at least three cycles ago, occupancy is the queue length, and the
// controller is full when the RAM-resident words (queue length minus the
// visible head) reach DEPTH-1.
// ---------------------------------------------------------------------------
module tb_b_io_l3_in_serialize_b_m_axi_fifo_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 63;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [AW:0]   if_num_data_valid;
  logic          mem_clk_en;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_din;
  logic [AW-1:0] mem_raddr;
  logic          mem_re;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  b_io_l3_in_serialize_b_m_axi_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
    .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .if_num_data_valid(if_num_data_valid),
    .mem_clk_en(mem_clk_en), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_din(mem_din), .mem_raddr(mem_raddr), .mem_re(mem_re),
    .mem_dout(mem_dout)
  );

  // Behavioural buffer RAM.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [AW-1:0] ram_raddr_q = '0;
  logic [DW-1:0] ram_dout_q;

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_din;
    ram_raddr_q <= mem_raddr;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset)      ram_dout_q <= '0;
    else if (mem_re) ram_dout_q <= ram[ram_raddr_q];
  end

  assign mem_dout = ram_dout_q;

  // Reference model.
  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } entry_t;

  entry_t q[$];
  int     t_now;
  int     checks = 0;
  int     errors = 0;

  // Per-step observations for the scenario tasks.
  logic          obs_empty;
  logic          obs_full;
  logic [DW-1:0] obs_dout;
  int            obs_num;
  bit            acc_push;
  bit            acc_pop;

  // One clock cycle: drive, sample at the falling edge, compare with the
  // model, then advance the model at the rising edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    bit            exp_e;
    bit            exp_f;
    int            exp_n;
    logic [DW-1:0] exp_d;
    if_write = w;
    if_din   = d;
    if_read  = r;
    @(negedge clk);
    exp_n = q.size();
    exp_e = (exp_n > 0) && (q[0].t <= t_now - 3);
    exp_f = !((exp_n - int'(exp_e)) == DEPTH - 1);
    exp_d = (exp_n > 0) ? q[0].data : '0;

    obs_empty = if_empty_n;
    obs_full  = if_full_n;
    obs_dout  = if_dout;
    obs_num   = int'(if_num_data_valid);

    checks++;
    if (if_empty_n !== exp_e) begin
      errors++;
      $display("FAIL empty_n t=%0d: got %b expected %b", t_now, if_empty_n, exp_e);
    end
    checks++;
    if (if_full_n !== exp_f) begin
      errors++;
      $display("FAIL full_n t=%0d: got %b expected %b", t_now, if_full_n, exp_f);
    end
    checks++;
    if (if_num_data_valid !== (AW+1)'(exp_n)) begin
      errors++;
      $display("FAIL num_data_valid t=%0d: got %0d expected %0d", t_now, if_num_data_valid, exp_n);
    end
    checks++;
    if (mem_we !== (w & exp_f)) begin
      errors++;
      $display("FAIL mem_we t=%0d: got %b expected %b", t_now, mem_we, w & exp_f);
    end
    if (exp_e) begin
      checks++;
      if (if_dout !== exp_d) begin
        errors++;
        $display("FAIL dout t=%0d: got %h expected %h", t_now, if_dout, exp_d);
      end
    end

    acc_pop  = r && exp_e;
    acc_push = w && exp_f;
    @(posedge clk);
    #1;
    if (acc_pop) void'(q.pop_front());
    if (acc_push) begin
      entry_t e;
      e.data = d;
      e.t    = t_now;
      q.push_back(e);
    end
    t_now++;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (if_empty_n !== 1'b0 || if_full_n !== 1'b1 || if_num_data_valid !== '0 ||
        mem_we !== 1'b0 || mem_raddr !== '0 || mem_re !== 1'b1 || mem_clk_en !== 1'b1) begin
      errors++;
      $display("FAIL %s: got empty_n=%b full_n=%b num=%0d we=%b raddr=%0d re=%b clk_en=%b expected 0 1 0 0 0 1 1",
               tag, if_empty_n, if_full_n, if_num_data_valid, mem_we, mem_raddr, mem_re, mem_clk_en);
    end
  endtask

  // Release reset and align to cycle 0 (#1 after a rising edge).
  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    t_now = 0;
  endtask

  task automatic test_reset();
    if_write = 1'b0;
    if_read  = 1'b0;
    reset    = 1'b0;
    #3;
    check_reset_outputs("reset_state");
    release_reset();
  endtask

  task automatic test_single();
    step(1'b1, 32'hA5A5_0001, 1'b0);
    checks++;
    if (obs_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_c0_empty_n: got %b expected 0", obs_empty);
    end
    for (int c = 1; c <= 2; c++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if (obs_empty !== 1'b0) begin
        errors++;
        $display("FAIL single_c%0d_empty_n: got %b expected 0", c, obs_empty);
      end
    end
    step(1'b0, '0, 1'b1);
    checks++;
    if (obs_empty !== 1'b1 || obs_dout !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_c3: got empty_n=%b dout=%h expected 1 a5a50001", obs_empty, obs_dout);
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if (obs_empty !== 1'b0 || obs_num !== 0) begin
      errors++;
      $display("FAIL single_c4: got empty_n=%b num=%0d expected 0 0", obs_empty, obs_num);
    end
  endtask

  task automatic test_fill_drain();
    int idx;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0);
      checks++;
      if (obs_full !== 1'b1) begin
        errors++;
        $display("FAIL fill_full_n word %0d: got %b expected 1", i, obs_full);
      end
    end
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (obs_full !== 1'b0 || obs_num !== DEPTH) begin
      errors++;
      $display("FAIL fill_full: got full_n=%b num=%0d expected 0 %0d", obs_full, obs_num, DEPTH);
    end
    step(1'b0, '0, 1'b0);
    idx = 0;
    for (int c = 0; c < 80; c++) begin
      step(1'b0, '0, 1'b1);
      if (obs_empty) begin
        checks++;
        if (obs_dout !== DW'(idx)) begin
          errors++;
          $display("FAIL drain_order pos %0d: got %h expected %h", idx, obs_dout, idx);
        end
        idx++;
      end
    end
    checks++;
    if (idx !== DEPTH) begin
      errors++;
      $display("FAIL drain_count: got %0d expected %0d", idx, DEPTH);
    end
  endtask

  task automatic test_stream();
    int  nxt, exp_v, maxn, gaps;
    bit  started;
    nxt = 1000; exp_v = 1000; maxn = 0; gaps = 0; started = 0;
    for (int c = 0; c < 500; c++) begin
      step(1'b1, DW'(nxt), 1'b1);
      if (acc_push) nxt++;
      if (obs_num > maxn) maxn = obs_num;
      if (obs_empty) begin
        started = 1;
        checks++;
        if (obs_dout !== DW'(exp_v)) begin
          errors++;
          $display("FAIL stream_order: got %h expected %h", obs_dout, exp_v);
        end
        exp_v++;
      end else if (started) begin
        gaps++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, '0, 1'b1);
      if (obs_empty) begin
        checks++;
        if (obs_dout !== DW'(exp_v)) begin
          errors++;
          $display("FAIL stream_tail: got %h expected %h", obs_dout, exp_v);
        end
        exp_v++;
      end
    end
    checks++;
    if (maxn > 3 || gaps != 0 || exp_v != 1500) begin
      errors++;
      $display("FAIL stream_summary: got max_num=%0d gaps=%0d last=%0d expected <=3 0 1500", maxn, gaps, exp_v);
    end
  endtask

  task automatic test_random_stall();
    int            nxt, exp_v;
    logic          r;
    logic          prev_hold;
    logic [DW-1:0] prev_dout;
    nxt = 5000; exp_v = 5000; prev_hold = 1'b0; prev_dout = '0;
    for (int c = 0; c < 3000 && exp_v < 5200; c++) begin
      r = 1'($urandom % 2);
      step(nxt < 5200, DW'(nxt), r);
      if (acc_push) nxt++;
      if (prev_hold && obs_empty) begin
        checks++;
        if (obs_dout !== prev_dout) begin
          errors++;
          $display("FAIL stall_stable: got %h expected %h", obs_dout, prev_dout);
        end
      end
      if (obs_empty && r) begin
        checks++;
        if (obs_dout !== DW'(exp_v)) begin
          errors++;
          $display("FAIL stall_order: got %h expected %h", obs_dout, exp_v);
        end
        exp_v++;
      end
      prev_hold = obs_empty & ~r;
      prev_dout = obs_dout;
    end
    checks++;
    if (exp_v != 5200) begin
      errors++;
      $display("FAIL stall_complete: got %0d expected 5200", exp_v);
    end
  endtask

  task automatic test_full_simul();
    int k, got, exp_v;
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(7000 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if (obs_num !== DEPTH || obs_full !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got num=%0d full_n=%b expected %0d 0", obs_num, obs_full, DEPTH);
    end
    k = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, DW'(8000 + k), 1'b1);
      if (c == 0 || c == 1) begin
        checks++;
        if (obs_full !== logic'(c == 1)) begin
          errors++;
          $display("FAIL full_simul_full_n c%0d: got %b expected %b", c, obs_full, c == 1);
        end
      end
      if (acc_push) k++;
    end
    // the 10 pops removed 7000..7009
    got = 10;
    for (int c = 0; c < 100; c++) begin
      step(1'b0, '0, 1'b1);
      if (obs_empty) begin
        exp_v = (got < DEPTH) ? 7000 + got : 8000 + got - DEPTH;
        checks++;
        if (obs_dout !== DW'(exp_v)) begin
          errors++;
          $display("FAIL full_simul_order: got %h expected %h", obs_dout, exp_v);
        end
        got++;
      end
    end
    checks++;
    if (got != DEPTH + k || k != 9) begin
      errors++;
      $display("FAIL full_simul_count: got %0d words k=%0d expected %0d k=9", got, k, DEPTH + 9);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    for (int i = 0; i < 20; i++) step(1'b1, DW'(9000 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if (obs_num !== 20) begin
      errors++;
      $display("FAIL mid_held: got %0d expected 20", obs_num);
    end
    if_write = 1'b0;
    if_read  = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset_async");
    checks++;
    if (if_dout !== '0) begin
      errors++;
      $display("FAIL mid_reset_dout: got %h expected 0", if_dout);
    end
    release_reset();
    step(1'b1, 32'h0000_1234, 1'b0);
    first = -1;
    for (int c = 1; c < 10; c++) begin
      step(1'b0, '0, 1'b1);
      if (obs_empty && first < 0) begin
        first = c;
        checks++;
        if (obs_dout !== 32'h0000_1234) begin
          errors++;
          $display("FAIL mid_next_word: got %h expected 00001234", obs_dout);
        end
      end
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL mid_latency: got cycle %0d expected 3", first);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_stream();
    test_random_stall();
    test_full_simul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
